puf_result_uart: RTL
====================

# puf_result_uart

Downstream drain stage for the PUF test harness. It snoops the harness's result-memory write port (`mem_we`, `mem_waddr`, `mem_din`) and keeps a local copy of the per-test pass counts. When the harness finishes writing, or when the host requests a resend, it serialises the stored bytes as one framed 8N1 UART packet for off-chip collection.

## Interface
- `CLKS_PER_BIT`, 868: clk_1 cycles per UART bit; legal range 2..65535.
- `DEPTH`, 16: result bytes held; power of two, ≤256.
- `clk_1` in 1: system clock, shared with the harness FSM.
- `rst` in 1: reset, synchronous, active-high; clock clk_1.
- `mem_we` in 1: harness write enable.
- `mem_waddr` in 13: harness write address.
- `mem_din` in 8: harness write data.
- `dump_req` in 1: one-cycle pulse; resend the stored frame.
- `uart_tx` out 1: serial output, idle high.
- `busy` out 1: high while a frame is being sent.
- `done` out 1: one-cycle pulse when a frame completes.

## Operation
- **Capture (IDLE only):**
  - On each cycle with `mem_we=1` and `mem_waddr < DEPTH`, write `buf[mem_waddr] <= mem_din`.
  - `count <= max(count, mem_waddr+1)`, using a 9-bit count.
  - Writes with `mem_waddr >= DEPTH` are ignored and do not change `count`.
  - Writes while `busy=1` are ignored.
- **Trigger:**
  - `we_d` is a registered copy of `mem_we`.
  - Trigger = (`we_d=1` and `mem_we=0`) or `dump_req=1`, evaluated only in IDLE.
  - A trigger while busy is dropped; nothing is queued.
- **Frame, in order:**
  - 0xA5
  - `count[7:0]`
  - `buf[0..count-1]`
  - `sum[7:0]`, the modulo-256 sum of the data bytes.
  - `count=0` gives frame A5 00 00.
- **Byte format:** 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- **Frame FSM:**
  - IDLE → HDR on trigger.
  - HDR → LEN.
  - LEN → DATA if `count>0`, else → SUM.
  - DATA advances an index after each byte; → SUM after index `count-1`.
  - SUM → IDLE.
  - Each transition happens when the bit engine finishes the current byte.
- **Bit engine:**
  - States: START, DATA (bit index 0..7), STOP.
  - A 16-bit cycle counter counts 0..CLKS_PER_BIT-1 per bit.
- **Checksum:** accumulated as bytes are loaded into the shift register, cleared at frame start. It does not depend on capture-time arithmetic.
- **Buffer persistence:** the buffer and `count` persist after a frame; `dump_req` resends identical bytes.
- **Reset values:** `uart_tx=1`, `busy=0`, `done=0`, `count=0`, `we_d=0`, FSM IDLE. Buffer contents are don't-care.
- **Reset mid-frame:** the line returns high on the next edge and no partial byte completes.

## Timing
- **Trigger cycle T** (the first cycle where `mem_we=0` after a 1, or the `dump_req` cycle):
  - At edge T+1: `busy=1` and `uart_tx=0` (start bit of 0xA5).
- Every bit lasts exactly `CLKS_PER_BIT` cycles. Each byte lasts `10*CLKS_PER_BIT` cycles; bytes are back-to-back with no idle gap.
- The frame occupies `(count+3)*10*CLKS_PER_BIT` cycles from T+1.
- After the last stop bit's final cycle:
  - `busy=0` and `done=1` for exactly one cycle.
  - The FSM is in IDLE.
  - A trigger in that same cycle starts a new frame at the next edge.
- **Capture latency:** a write at edge E is visible to a frame triggered at T ≥ E+1.
  - The write in the final `mem_we=1` cycle is captured, because the trigger fires only one cycle later.

## Test plan
- Use `CLKS_PER_BIT=4` throughout. Check `uart_tx` bit-by-bit with a sampling model.
- **Normal dump:** write addresses 0..7 with 0x10..0x17, then drop `mem_we`.
  - Expect frame A5 08 10 11 12 13 14 15 16 17 9C.
  - `busy` high for 440 cycles, one `done` pulse.
- **Empty dump:** `dump_req` right after reset → A5 00 00, 120 cycles.
- **Out-of-range and overwrite:** write addr 3=0xFF, addr 20=0x55, then addr 3=0x01, then drop `mem_we`.
  - Expect `count=4`; frame A5 04 xx xx xx 01 with checksum over the 4 bytes. Preload 0..2 with 0 → checksum 01.
- **Busy blocking:** during the frame, pulse `dump_req` and issue `mem_we` writes to addr 0.
  - The frame is unchanged and no second frame follows.
  - A later `dump_req` resends the original data.
- **Reset mid-frame:** assert `rst` during data bit 3 of the LEN byte.
  - `uart_tx=1` and `busy=0` on the next edge; no `done`.
  - A subsequent `dump_req` yields A5 00 00.
- **Back-to-back:** `dump_req` in the `done` cycle → second frame's start bit begins at the next edge, with no idle bit between frames.

Source files
------------

// File: rtl/puf_result_uart_if.sv
// Harness-facing bundle for puf_result_uart: result-memory snoop port, resend request
// and the UART drain outputs.
interface puf_result_uart_if;
  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [7:0]  mem_din;
  logic        dump_req;
  logic        uart_tx;
  logic        busy;
  logic        done;

  modport master (
    output mem_we, mem_waddr, mem_din, dump_req,
    input  uart_tx, busy, done
  );

  modport slave (
    input  mem_we, mem_waddr, mem_din, dump_req,
    output uart_tx, busy, done
  );
endinterface

// File: rtl/puf_result_uart.sv
// Snoops the harness result-memory writes into a local buffer and drains it as one
// framed 8N1 UART packet: A5, count, data bytes, modulo-256 checksum.
module puf_result_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 16
) (
  input  logic             clk_1,
  input  logic             rst,
  puf_result_uart_if.slave bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SYNC     = 8'hA5;

  typedef enum logic [2:0] {F_IDLE, F_HDR, F_LEN, F_DATA, F_SUM} frame_e;
  typedef enum logic [1:0] {B_START, B_DATA, B_STOP} bit_e;

  frame_e      r_fstate, w_fstate_nxt;
  bit_e        r_bstate, w_bstate_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [7:0]  r_byte, w_byte_nxt;
  logic [7:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_sum, w_sum_nxt;
  logic [8:0]  r_count;
  logic        r_we_d;
  logic        r_tx, r_busy, r_done;
  logic        w_tx_nxt, w_busy_nxt, w_done_nxt;
  logic [7:0]  r_buf [DEPTH];

  logic        w_idle, w_trigger, w_bit_end, w_byte_end, w_wr_ok, w_last_data;
  logic [8:0]  w_waddr_p1;
  logic [7:0]  w_next_data;

  assign w_idle      = (r_fstate == F_IDLE);
  assign w_trigger   = w_idle && ((r_we_d && !bus.mem_we) || bus.dump_req);
  assign w_bit_end   = !w_idle && (r_cnt == BIT_LAST);
  assign w_byte_end  = w_bit_end && (r_bstate == B_STOP);
  assign w_wr_ok     = w_idle && bus.mem_we && (bus.mem_waddr < 13'(DEPTH));
  assign w_waddr_p1  = 9'(bus.mem_waddr[AW-1:0]) + 9'd1;
  assign w_last_data = ((9'(r_idx) + 9'd1) == r_count);
  assign w_next_data = r_buf[AW'(r_idx + 8'd1)];

  assign bus.uart_tx = r_tx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  // Result buffer has no reset; only bytes below count are ever sent.
  always_ff @(posedge clk_1) begin
    if (w_wr_ok) r_buf[bus.mem_waddr[AW-1:0]] <= bus.mem_din;
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      r_fstate  <= F_IDLE;
      r_bstate  <= B_START;
      r_bit_idx <= 3'd0;
      r_cnt     <= 16'd0;
      r_byte    <= 8'd0;
      r_idx     <= 8'd0;
      r_sum     <= 8'd0;
      r_count   <= 9'd0;
      r_we_d    <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fstate  <= w_fstate_nxt;
      r_bstate  <= w_bstate_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_byte    <= w_byte_nxt;
      r_idx     <= w_idx_nxt;
      r_sum     <= w_sum_nxt;
      r_we_d    <= bus.mem_we;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_wr_ok && (w_waddr_p1 > r_count)) r_count <= w_waddr_p1;
    end
  end

  // Frame sequencing and bit timing; the next byte is loaded at the end of each stop bit.
  always_comb begin
    w_fstate_nxt  = r_fstate;
    w_bstate_nxt  = r_bstate;
    w_bit_idx_nxt = r_bit_idx;
    w_cnt_nxt     = r_cnt;
    w_byte_nxt    = r_byte;
    w_idx_nxt     = r_idx;
    w_sum_nxt     = r_sum;
    if (w_trigger) begin
      w_fstate_nxt  = F_HDR;
      w_bstate_nxt  = B_START;
      w_bit_idx_nxt = 3'd0;
      w_cnt_nxt     = 16'd0;
      w_byte_nxt    = SYNC;
      w_idx_nxt     = 8'd0;
      w_sum_nxt     = 8'd0;
    end else if (!w_idle) begin
      if (!w_bit_end) begin
        w_cnt_nxt = r_cnt + 16'd1;
      end else begin
        w_cnt_nxt = 16'd0;
        case (r_bstate)
          B_START: begin
            w_bstate_nxt  = B_DATA;
            w_bit_idx_nxt = 3'd0;
          end
          B_DATA: begin
            if (r_bit_idx == 3'd7) w_bstate_nxt = B_STOP;
            else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
          default: begin
            w_bstate_nxt = B_START;
            case (r_fstate)
              F_HDR: begin
                w_fstate_nxt = F_LEN;
                w_byte_nxt   = r_count[7:0];
              end
              F_LEN: begin
                if (r_count != 9'd0) begin
                  w_fstate_nxt = F_DATA;
                  w_byte_nxt   = r_buf[0];
                  w_sum_nxt    = r_sum + r_buf[0];
                  w_idx_nxt    = 8'd0;
                end else begin
                  w_fstate_nxt = F_SUM;
                  w_byte_nxt   = r_sum;
                end
              end
              F_DATA: begin
                if (w_last_data) begin
                  w_fstate_nxt = F_SUM;
                  w_byte_nxt   = r_sum;
                end else begin
                  w_byte_nxt = w_next_data;
                  w_sum_nxt  = r_sum + w_next_data;
                  w_idx_nxt  = r_idx + 8'd1;
                end
              end
              default: w_fstate_nxt = F_IDLE;
            endcase
          end
        endcase
      end
    end
  end

  // Outputs are registered from the next state so the line follows the bit engine exactly.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_fstate_nxt == F_IDLE) begin
      w_done_nxt = (r_fstate == F_SUM) && w_byte_end;
    end else begin
      w_busy_nxt = 1'b1;
      case (w_bstate_nxt)
        B_START: w_tx_nxt = 1'b0;
        B_DATA:  w_tx_nxt = w_byte_nxt[w_bit_idx_nxt];
        default: w_tx_nxt = 1'b1;
      endcase
    end
  end

endmodule
